// File: rtl/csr_pkg.sv
// Shared constants and types for the supervisor CSR write-port sequencer.
// Covers CSR addresses, Zicsr funct3 codes, sstatus bit positions and FSM states.
package csr_pkg;

    localparam logic [11:0] CSR_SSTATUS = 12'h100;
    localparam logic [11:0] CSR_STVEC   = 12'h105;
    localparam logic [11:0] CSR_SEPC    = 12'h141;
    localparam logic [11:0] CSR_SCAUSE  = 12'h142;
    localparam logic [11:0] CSR_STVAL   = 12'h143;

    localparam logic [2:0] F3_RW  = 3'b001;
    localparam logic [2:0] F3_RS  = 3'b010;
    localparam logic [2:0] F3_RC  = 3'b011;
    localparam logic [2:0] F3_RWI = 3'b101;
    localparam logic [2:0] F3_RSI = 3'b110;
    localparam logic [2:0] F3_RCI = 3'b111;

    localparam int SIE_BIT  = 1;
    localparam int SPIE_BIT = 5;
    localparam int SPP_BIT  = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_C_RMW,
        ST_T_SEPC,
        ST_T_SCAUSE,
        ST_T_STVAL,
        ST_T_SSTATUS,
        ST_R_SSTATUS,
        ST_DONE
    } state_t;

    // The top two address bits set mark a read-only CSR.
    function automatic logic csr_is_ro(input logic [11:0] addr);
        return addr[11:10] == 2'b11;
    endfunction

endpackage

// File: rtl/csr_rmw_alu.sv
// Combinational read-modify-write for Zicsr instructions.
// Set/clear forms with rs1/zimm index 0 only read, so they report no write.
module csr_rmw_alu
    import csr_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [31:0] old_val,
    input  logic [31:0] src_val,
    input  logic [4:0]  rs1_idx,
    output logic [31:0] new_val,
    output logic        wr_en
);

    always_comb begin
        new_val = old_val;
        wr_en   = 1'b0;
        case (funct3)
            F3_RW, F3_RWI: begin
                new_val = src_val;
                wr_en   = 1'b1;
            end
            F3_RS, F3_RSI: begin
                new_val = old_val | src_val;
                wr_en   = (rs1_idx != 5'd0);
            end
            F3_RC, F3_RCI: begin
                new_val = old_val & ~src_val;
                wr_en   = (rs1_idx != 5'd0);
            end
            default: begin
                new_val = old_val;
                wr_en   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/csr_sequencer.sv
// Owns the single CSR-file write port and sequences Zicsr RMW, trap entry and SRET over it.
// Returns the old CSR value, an illegal flag and the redirect target to the core.
module csr_sequencer
    import csr_pkg::*;
#(
    parameter bit P_VECTORED = 1'b1,
    parameter bit P_CHECK_RO = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_csr_valid,
    input  logic [2:0]  i_csr_funct3,
    input  logic [11:0] i_csr_addr,
    input  logic [31:0] i_rs1_data,
    input  logic [4:0]  i_rs1_idx,
    input  logic        i_trap_valid,
    input  logic [31:0] i_trap_cause,
    input  logic [31:0] i_trap_pc,
    input  logic [31:0] i_trap_tval,
    input  logic        i_trap_priv,
    input  logic        i_sret_valid,
    input  logic [31:0] i_csr_regout,
    input  logic [31:0] i_stvec,
    input  logic [31:0] i_sepc,
    output logic [11:0] o_csr_select,
    output logic [31:0] o_csr_data,
    output logic        o_csr_load,
    output logic        o_ready,
    output logic        o_done,
    output logic [31:0] o_rd_data,
    output logic        o_illegal,
    output logic        o_redirect,
    output logic [31:0] o_redirect_pc,
    output logic        o_redirect_priv
);

    state_t      state, state_nxt;
    logic [2:0]  req_funct3;
    logic [11:0] req_addr;
    logic [31:0] req_rs1_data;
    logic [4:0]  req_rs1_idx;
    logic [31:0] req_cause;
    logic [31:0] req_pc;
    logic [31:0] req_tval;
    logic        req_priv;
    logic [11:0] sel_last;
    logic        illegal_q;
    logic        redirect_q;

    logic        accept;
    logic [31:0] rmw_src;
    logic [31:0] rmw_new;
    logic        rmw_we;
    logic        ro_block;
    logic [31:0] trap_sstatus;
    logic [31:0] sret_sstatus;
    logic [31:0] stvec_base;
    logic [31:0] trap_target;

    assign accept   = (state == ST_IDLE) && (i_trap_valid || i_sret_valid || i_csr_valid);
    assign rmw_src  = req_funct3[2] ? {27'd0, req_rs1_idx} : req_rs1_data;
    assign ro_block = rmw_we && csr_is_ro(req_addr);

    csr_rmw_alu u_alu (
        .funct3  (req_funct3),
        .old_val (i_csr_regout),
        .src_val (rmw_src),
        .rs1_idx (req_rs1_idx),
        .new_val (rmw_new),
        .wr_en   (rmw_we)
    );

    always_comb begin
        trap_sstatus           = i_csr_regout;
        trap_sstatus[SPIE_BIT] = i_csr_regout[SIE_BIT];
        trap_sstatus[SIE_BIT]  = 1'b0;
        trap_sstatus[SPP_BIT]  = req_priv;
        sret_sstatus           = i_csr_regout;
        sret_sstatus[SIE_BIT]  = i_csr_regout[SPIE_BIT];
        sret_sstatus[SPIE_BIT] = 1'b1;
        sret_sstatus[SPP_BIT]  = 1'b0;
    end

    // Vectoring applies to interrupts only; MODE 1x falls back to direct. Offset wraps mod 2^32.
    assign stvec_base  = {i_stvec[31:2], 2'b00};
    assign trap_target = (P_VECTORED && (i_stvec[1:0] == 2'b01) && req_cause[31])
                       ? stvec_base + {req_cause[29:0], 2'b00}
                       : stvec_base;

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (i_trap_valid)      state_nxt = ST_T_SEPC;
                else if (i_sret_valid) state_nxt = ST_R_SSTATUS;
                else if (i_csr_valid)  state_nxt = ST_C_RMW;
            end
            ST_T_SEPC:    state_nxt = ST_T_SCAUSE;
            ST_T_SCAUSE:  state_nxt = ST_T_STVAL;
            ST_T_STVAL:   state_nxt = ST_T_SSTATUS;
            ST_C_RMW,
            ST_T_SSTATUS,
            ST_R_SSTATUS: state_nxt = ST_DONE;
            default:      state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        o_csr_select = sel_last;
        o_csr_data   = 32'd0;
        o_csr_load   = 1'b0;
        case (state)
            ST_C_RMW: begin
                o_csr_select = req_addr;
                if (rmw_we && !ro_block) begin
                    o_csr_data = rmw_new;
                    o_csr_load = 1'b1;
                end
            end
            ST_T_SEPC: begin
                o_csr_select = CSR_SEPC;
                o_csr_data   = {req_pc[31:1], 1'b0};
                o_csr_load   = 1'b1;
            end
            ST_T_SCAUSE: begin
                o_csr_select = CSR_SCAUSE;
                o_csr_data   = req_cause;
                o_csr_load   = 1'b1;
            end
            ST_T_STVAL: begin
                o_csr_select = CSR_STVAL;
                o_csr_data   = req_tval;
                o_csr_load   = 1'b1;
            end
            ST_T_SSTATUS: begin
                o_csr_select = CSR_SSTATUS;
                o_csr_data   = trap_sstatus;
                o_csr_load   = 1'b1;
            end
            ST_R_SSTATUS: begin
                o_csr_select = CSR_SSTATUS;
                o_csr_data   = sret_sstatus;
                o_csr_load   = 1'b1;
            end
            default: ;
        endcase
        // A reset arriving mid-sequence must not let the in-flight write land.
        if (i_rst) begin
            o_csr_data = 32'd0;
            o_csr_load = 1'b0;
        end
        o_ready    = (state == ST_IDLE);
        o_done     = (state == ST_DONE);
        o_illegal  = (state == ST_DONE) && illegal_q;
        o_redirect = (state == ST_DONE) && redirect_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            req_funct3      <= 3'd0;
            req_addr        <= 12'd0;
            req_rs1_data    <= 32'd0;
            req_rs1_idx     <= 5'd0;
            req_cause       <= 32'd0;
            req_pc          <= 32'd0;
            req_tval        <= 32'd0;
            req_priv        <= 1'b0;
            sel_last        <= 12'd0;
            o_rd_data       <= 32'd0;
            illegal_q       <= 1'b0;
            redirect_q      <= 1'b0;
            o_redirect_pc   <= 32'd0;
            o_redirect_priv <= 1'b0;
        end else begin
            sel_last <= o_csr_select;
            if (accept) begin
                req_funct3   <= i_csr_funct3;
                req_addr     <= i_csr_addr;
                req_rs1_data <= i_rs1_data;
                req_rs1_idx  <= i_rs1_idx;
                req_cause    <= i_trap_cause;
                req_pc       <= i_trap_pc;
                req_tval     <= i_trap_tval;
                req_priv     <= i_trap_priv;
                illegal_q    <= 1'b0;
                redirect_q   <= 1'b0;
            end
            case (state)
                ST_C_RMW: begin
                    o_rd_data <= (P_CHECK_RO && ro_block) ? 32'd0 : i_csr_regout;
                    illegal_q <= P_CHECK_RO && ro_block;
                end
                ST_T_SSTATUS: begin
                    redirect_q      <= 1'b1;
                    o_redirect_pc   <= trap_target;
                    o_redirect_priv <= 1'b1;
                end
                ST_R_SSTATUS: begin
                    redirect_q      <= 1'b1;
                    o_redirect_pc   <= i_sepc;
                    o_redirect_priv <= i_csr_regout[SPP_BIT];
                end
                default: ;
            endcase
        end
    end

endmodule
